// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-channel, W-bit stream multiplexer with valid/ready handshakes on every
// input and on the output. Channels are picked either by a round-robin
// arbiter (mode = 0) or by a fixed channel index (mode = 1). The chosen word
// lands in a single output register stage.
//
// Ports:
//   clk        single clock, everything on the rising edge
//   rst        synchronous active-high reset
//   in_data    CH*WIDTH packed input data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high per cycle
//   mode       0 = round-robin, 1 = fixed select
//   sel        channel index used in fixed mode (values >= CH never grant)
//   out_data   registered output data
//   out_ch     index of the channel that supplied out_data
//   out_valid  registered output valid
//   out_ready  downstream ready
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SEL_W = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   in_data,
    input  logic [CH-1:0]         in_valid,
    output logic [CH-1:0]         in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    logic             xfer;

    // The output register can take a new word when it is empty or when its
    // current word is leaving on this edge. Reset blocks every transfer.
    assign load_en = !out_valid || out_ready;
    assign xfer    = !rst && load_en && grant_vld;

    // Arbitration. The round-robin scan is split into two passes, first the
    // channels at or above ptr and then the ones below it, which gives the
    // wrapped priority order without modulo arithmetic on a non-power-of-two
    // channel count. In fixed mode the index is compared against every real
    // channel, so an out-of-range sel simply matches nothing.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (!mode) begin
            for (int k = 0; k < CH; k++) begin
                if (!grant_vld && k >= int'(ptr) && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(k);
                end
            end
            for (int k = 0; k < CH; k++) begin
                if (!grant_vld && k < int'(ptr) && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(k);
                end
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (int'(sel) == k && in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_W'(k);
                end
            end
        end
    end

    // Data select for the granted channel and the one-hot ready back to it.
    // Ready is only raised when the transfer will really happen, so a channel
    // that is not valid, or any channel during reset, never sees ready.
    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < CH; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = xfer;
            end
        end
    end

    // Output register and round-robin pointer. The pointer moves past the
    // granted channel on every transfer in both modes, so leaving fixed mode
    // resumes the rotation just after the last channel served. When nothing
    // loads, out_data and out_ch keep their last values and only out_valid
    // drops once the word has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (xfer) begin
            out_data  <= grant_data;
            out_ch    <= grant;
            out_valid <= 1'b1;
            if (int'(grant) == CH - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Scoreboard bench for stream_mux_rr. Two instances are built, one with
// 8 channels and one with 6 channels (out-of-range select and non-power-of-two
// wrap). A single stimulus driver talks to both; the variable cur picks which
// instance is observed and modelled. The driver pushes every word the model
// says is accepted into a queue; an independent monitor pops and compares it
// when the observed instance hands a word downstream.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0]  in_valid = '0;
    logic        mode = 1'b0;
    logic [2:0]  sel = '0;
    logic        out_ready = 1'b1;
    logic        cur = 1'b0;

    logic [7:0]  ready8;
    logic [7:0]  out_data8;
    logic [2:0]  out_ch8;
    logic        out_valid8;
    logic [5:0]  ready6;
    logic [7:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;

    logic [7:0]  obs_in_ready;
    logic [7:0]  obs_out_data;
    logic [2:0]  obs_out_ch;
    logic        obs_out_valid;

    logic [7:0]  chan_data [8];
    logic [10:0] sb [$];
    logic [10:0] seen [$];
    logic [10:0] exp_seen [$];
    logic        model_full = 1'b0;
    int          mptr = 0;
    int          last_xfer = -1;
    int          n_checks = 0;
    int          n_errors = 0;

    stream_mux_rr #(.WIDTH(8), .CH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (ready8),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data8),
        .out_ch    (out_ch8),
        .out_valid (out_valid8),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .CH(6)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data[47:0]),
        .in_valid  (in_valid[5:0]),
        .in_ready  (ready6),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data6),
        .out_ch    (out_ch6),
        .out_valid (out_valid6),
        .out_ready (out_ready)
    );

    assign obs_in_ready  = cur ? {2'b00, ready6} : ready8;
    assign obs_out_data  = cur ? out_data6 : out_data8;
    assign obs_out_ch    = cur ? out_ch6 : out_ch8;
    assign obs_out_valid = cur ? out_valid6 : out_valid8;

    always #5 clk = ~clk;

    // Reference arbiter: returns the channel the rules pick, or -1.
    function automatic int modelGrant(input int nch, input logic [7:0] v,
                                      input logic m, input int s, input int p);
        if (m) begin
            if (s < nch && v[s]) return s;
            return -1;
        end
        for (int i = 0; i < nch; i++) begin
            if (v[(p + i) % nch]) return (p + i) % nch;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then check the
    // combinational ready and the registered valid against the model and
    // advance the model as the coming rising edge will.
    task automatic applyStimulus(input logic r, input logic [7:0] v, input logic m,
                                 input logic [2:0] s, input logic ordy);
        int         nch;
        int         g;
        logic       load;
        logic [7:0] exp_rdy;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = ordy;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = chan_data[k];
        #1;
        nch     = cur ? 6 : 8;
        g       = modelGrant(nch, v, m, int'(s), mptr);
        load    = !model_full || ordy;
        exp_rdy = (!r && load && g >= 0) ? 8'(1 << g) : 8'h00;
        checkOutput("in_ready", 16'(obs_in_ready), 16'(exp_rdy));
        checkOutput("out_valid", 16'(obs_out_valid), 16'(model_full));
        last_xfer = -1;
        if (r) begin
            model_full = 1'b0;
            mptr       = 0;
            sb.delete();
        end else if (exp_rdy != 8'h00) begin
            sb.push_back({3'(g), chan_data[g]});
            model_full = 1'b1;
            mptr       = (g + 1) % nch;
            last_xfer  = g;
        end else if (ordy) begin
            model_full = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    endtask

    // Silently reset both instances and point the observation at one of them.
    task automatic switchDut(input logic c);
        @(negedge clk);
        cur       = c;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        model_full = 1'b0;
        mptr       = 0;
        last_xfer  = -1;
        sb.delete();
        seen.delete();
    endtask

    task automatic checkSeen(input string name);
        checkOutput({name, "_count"}, 16'(seen.size()), 16'(exp_seen.size()));
        for (int i = 0; i < seen.size() && i < exp_seen.size(); i++) begin
            checkOutput(name, 16'(seen[i]), 16'(exp_seen[i]));
        end
        seen.delete();
        exp_seen.delete();
    endtask

    // Monitor: compares the presented word with the scoreboard head every
    // cycle it is valid, and retires it when downstream takes it.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && obs_out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL out_word: got %h, expected no word at %0t",
                             {obs_out_ch, obs_out_data}, $time);
                end else begin
                    checkOutput("out_word", 16'({obs_out_ch, obs_out_data}), 16'(sb[0]));
                    if (out_ready) begin
                        seen.push_back({obs_out_ch, obs_out_data});
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] pending;
        logic [7:0] v;
        logic [7:0] mask;
        for (int k = 0; k < 8; k++) chan_data[k] = 8'h10 + 8'(k);

        // Reset with every channel valid, then round-robin fairness.
        switchDut(1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1);
            checkOutput("rst_out_data", 16'(obs_out_data), 16'h0000);
            checkOutput("rst_out_ch", 16'(obs_out_ch), 16'h0000);
        end
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 1'b1);
        drain(2);
        for (int i = 0; i < 10; i++) exp_seen.push_back({3'(i % 8), 8'h10 + 8'(i % 8)});
        checkSeen("fair_seq");

        // Sparse valids: grant 2 moves the pointer to 3, then 5, 2, 5.
        chan_data[2] = 8'h22;
        chan_data[5] = 8'h55;
        applyStimulus(1'b0, 8'h04, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h24, 1'b0, 3'd0, 1'b1);
        drain(2);
        exp_seen.push_back({3'd2, 8'h22});
        exp_seen.push_back({3'd5, 8'h55});
        exp_seen.push_back({3'd2, 8'h22});
        exp_seen.push_back({3'd5, 8'h55});
        checkSeen("sparse_seq");

        // Backpressure on a held 0xA5.
        switchDut(1'b0);
        chan_data[0] = 8'hA5;
        chan_data[1] = 8'h3C;
        applyStimulus(1'b0, 8'h01, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h02, 1'b0, 3'd0, 1'b0);
            checkOutput("bp_hold_data", 16'(obs_out_data), 16'h00A5);
        end
        applyStimulus(1'b0, 8'h02, 1'b0, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        checkOutput("bp_next_data", 16'(obs_out_data), 16'h003C);
        drain(1);
        exp_seen.push_back({3'd0, 8'hA5});
        exp_seen.push_back({3'd1, 8'h3C});
        checkSeen("bp_seq");

        // Reset while a word is held under backpressure.
        chan_data[3] = 8'h77;
        applyStimulus(1'b0, 8'h08, 1'b0, 3'd0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        checkOutput("midrst_valid", 16'(obs_out_valid), 16'h0000);
        for (int k = 0; k < 8; k++) chan_data[k] = 8'h10 + 8'(k);
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 1'b1);
        drain(2);
        exp_seen.push_back({3'd0, 8'h10});
        checkSeen("midrst_seq");

        // Six channels: fixed select 4, out-of-range 7, then back to round-robin.
        switchDut(1'b1);
        for (int k = 0; k < 8; k++) chan_data[k] = 8'h60 + 8'(k);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h3F, 1'b1, 3'd4, 1'b1);
        applyStimulus(1'b0, 8'h3F, 1'b1, 3'd7, 1'b1);
        applyStimulus(1'b0, 8'h3F, 1'b1, 3'd7, 1'b1);
        checkOutput("sel7_valid", 16'(obs_out_valid), 16'h0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h3F, 1'b0, 3'd0, 1'b1);
        drain(2);
        for (int i = 0; i < 4; i++) exp_seen.push_back({3'd4, 8'h64});
        exp_seen.push_back({3'd5, 8'h65});
        exp_seen.push_back({3'd0, 8'h60});
        exp_seen.push_back({3'd1, 8'h61});
        checkSeen("fixed_seq");

        // Random traffic on both instances, keeping each valid raised until
        // its word is taken.
        for (int d = 0; d < 2; d++) begin
            switchDut(d[0]);
            mask    = d[0] ? 8'h3F : 8'hFF;
            pending = '0;
            for (int i = 0; i < 300; i++) begin
                v = pending | (8'($urandom) & mask);
                for (int k = 0; k < 8; k++) begin
                    if (v[k] && !pending[k]) chan_data[k] = 8'($urandom);
                end
                applyStimulus(1'b0, v, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                              ($urandom_range(0, 3) != 0));
                pending = v;
                if (last_xfer >= 0) pending[last_xfer] = 1'b0;
            end
            drain(3);
            checkOutput("sb_empty", 16'(sb.size()), 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output, selecting either by round-robin arbitration or by a fixed channel select. It is the successor of the combinational 8:1 bit mux: wider data, any channel count, registered output and flow control. It sits between multiple producer streams and a single downstream consumer, in the same datapath role as the plain mux.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (>= 1)
- CH, 8, number of input channels (>= 2, need not be a power of two)
- SEL_W, $clog2(CH), width of channel index (derived; do not override)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CH  per-channel valid
- in_ready  output  CH  per-channel ready; at most one bit high per cycle
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  SEL_W  channel index used when mode = 1
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  index of channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready

## Operation
- One output register stage (out_data, out_ch, out_valid) plus a round-robin pointer ptr (SEL_W bits).
- load_en = !out_valid || out_ready.
- Grant, combinational:
  - mode 0: first k with in_valid[k], scanning ptr, ptr+1, ..., CH-1, 0, ..., ptr-1; none if in_valid == 0.
  - mode 1: k = sel if sel < CH and in_valid[sel]; otherwise none. sel >= CH never grants.
- in_ready[k] = load_en && (grant == k). All other in_ready bits are 0. A channel with in_valid = 0 never sees in_ready = 1.
- Transfer on channel g (in_valid[g] && in_ready[g]): next edge out_data <= channel g data, out_ch <= g, out_valid <= 1, ptr <= (g == CH-1) ? 0 : g+1.
- No transfer and out_ready = 1: out_valid <= 0; out_data and out_ch hold their last values.
- No transfer and out_ready = 0: all output registers hold.
- ptr updates on every transfer, in both modes. In mode 1, ptr tracks the last granted channel, so switching back to mode 0 resumes fairly.
- mode and sel are sampled combinationally every cycle. A change affects only the next grant, never data already in the output register.
- Reset: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready is 0 during reset regardless of inputs. Reset mid-transfer drops the held word; any word presented in the reset cycle is not accepted.

## Timing
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Throughput: 1 word per cycle while out_ready stays high. No bubble on back-to-back grants, whether from the same or different channels.
- in_ready depends combinationally on in_valid, mode, sel, out_ready and out_valid. There is no combinational path from in_data to any output.
- While out_valid = 1 and out_ready = 0, out_data and out_ch are stable and in_ready = 0.
- Upstream protocol: once in_valid[k] rises it holds, with stable data, until a transfer. The block does not check this rule.
- Simultaneous out_ready = 1 and a new grant in the same cycle: the old word leaves and the new word loads on the same edge.
- Fairness, mode 0: with all CH channels continuously valid and out_ready = 1, grants cycle 0, 1, ..., CH-1, 0 with no repeats.

## Test plan
- Reset/idle: assert rst for 2 cycles with all in_valid = 1. Required: in_ready = 0, out_valid = 0, out_data = 0, out_ch = 0 throughout. After release, first grant is channel 0.
- Round-robin fairness (CH = 8, WIDTH = 8, mode 0): channel k holds 0x10+k, all valid, out_ready = 1. Required: out_ch sequence 0..7, 0, 1 and out_data 0x10..0x17, 0x10, 0x11 on consecutive cycles, one word per cycle.
- Sparse valids: only channels 2 and 5 valid, ptr = 3 after a prior grant. Required: grant 5, then 2, then 5. in_ready stays 0 on every other channel.
- Backpressure: hold out_ready = 0 for 4 cycles after out_valid rises with out_data = 0xA5. Required: out_data = 0xA5 held, all in_ready = 0. The cycle out_ready returns to 1, the next word transfers and appears 1 cycle later.
- Fixed mode and out-of-range select (CH = 6, SEL_W = 3): mode 1, sel = 4, all valid. Required: only channel 4 is granted, every cycle. With sel = 7: no grant and out_valid falls. Switching to mode 0 after a grant on 4: next grant is channel 5.
- Reset mid-stream: assert rst while out_valid = 1 and out_ready = 0. Required: out_valid = 0 on the next edge, the held word is lost, and ptr restarts at 0.
